memory_lane_sequencer: RTL and testbench

MEMORY_LANE_SEQUENCER -- requirements
Module: memory_lane_sequencer

---
 rtl/gpu_pkg.sv | 16 +
 rtl/memory_lane_sequencer.sv | 144 ++++++++++++++
 tb/tb_memory_lane_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared widths, lane vector type and sequencer state encoding for the
// EX/MEM -> MEM/WB memory stage of the vector GPU pipeline.
package gpu_pkg;

    localparam int N     = 18;
    localparam int LANES = 3;
    localparam int AW    = 10;

    typedef logic [LANES-1:0][N-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/memory_lane_sequencer.sv
// Memory stage sequencer: ALU ops pass straight to MEM/WB in one cycle, loads
// and stores are serialised lane by lane over a single-port data memory.
module memory_lane_sequencer
    import gpu_pkg::*;
#(
    parameter int N     = gpu_pkg::N,
    parameter int LANES = gpu_pkg::LANES,
    parameter int AW    = gpu_pkg::AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [LANES-1:0][N-1:0]   alu_result,
    input  logic [AW-1:0]             ld_base,
    input  logic [AW-1:0]             st_base,
    input  logic [LANES-1:0][N-1:0]   write_data,
    input  logic [3:0]                wa3,
    input  logic                      pcsrc,
    input  logic                      regwrite,
    input  logic                      memtoreg,
    input  logic                      memwrite,
    output logic                      stall,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [AW-1:0]             dmem_addr,
    output logic [N-1:0]              dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [N-1:0]              dmem_rdata,
    output logic                      out_valid,
    output logic [LANES-1:0][N-1:0]   out_alu_result,
    output logic [LANES-1:0][N-1:0]   out_read_data,
    output logic [3:0]                out_wa3,
    output logic                      out_pcsrc,
    output logic                      out_regwrite,
    output logic                      out_memtoreg
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    state_t                    state;
    logic [LW-1:0]             lane;
    logic [LANES-1:0][N-1:0]   alu_q;
    logic [LANES-1:0][N-1:0]   wdata_q;
    logic [LANES-1:0][N-1:0]   rdata_q;
    logic [AW-1:0]             base_q;
    logic [3:0]                wa3_q;
    logic                      pcsrc_q;
    logic                      regwrite_q;
    logic                      memtoreg_q;
    logic                      store_q;

    logic                      in_access;
    logic                      lane_done;
    logic [LANES-1:0][N-1:0]   rdata_next;

    assign in_access  = (state == ACCESS);
    assign stall      = in_access;
    assign dmem_req   = in_access;
    assign dmem_we    = in_access && store_q;
    // Address and data come only from captured state, so they cannot move until ack.
    assign dmem_addr  = in_access ? AW'(base_q + AW'(lane)) : '0;
    assign dmem_wdata = in_access ? wdata_q[lane] : '0;
    assign lane_done  = in_access && dmem_ack;

    always_comb begin
        // NOTE: default first so the conditional lane update cannot infer a latch.
        rdata_next = rdata_q;
        if (lane_done && !store_q) begin
            rdata_next[lane] = dmem_rdata;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lane           <= '0;
            alu_q          <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            base_q         <= '0;
            wa3_q          <= '0;
            pcsrc_q        <= 1'b0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            store_q        <= 1'b0;
            out_valid      <= 1'b0;
            out_alu_result <= '0;
            out_read_data  <= '0;
            out_wa3        <= '0;
            out_pcsrc      <= 1'b0;
            out_regwrite   <= 1'b0;
            out_memtoreg   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !memwrite && !memtoreg) begin
                        out_valid      <= 1'b1;
                        out_alu_result <= alu_result;
                        out_read_data  <= '0;
                        out_wa3        <= wa3;
                        out_pcsrc      <= pcsrc;
                        out_regwrite   <= regwrite;
                        out_memtoreg   <= memtoreg;
                    end else if (in_valid) begin
                        state      <= ACCESS;
                        lane       <= '0;
                        alu_q      <= alu_result;
                        wdata_q    <= write_data;
                        rdata_q    <= '0;
                        base_q     <= memwrite ? st_base : ld_base;
                        wa3_q      <= wa3;
                        pcsrc_q    <= pcsrc;
                        regwrite_q <= regwrite;
                        memtoreg_q <= memtoreg;
                        store_q    <= memwrite;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        rdata_q <= rdata_next;
                        if (lane == LAST_LANE) begin
                            state          <= IDLE;
                            lane           <= '0;
                            out_valid      <= 1'b1;
                            out_alu_result <= alu_q;
                            out_read_data  <= store_q ? '0 : rdata_next;
                            out_wa3        <= wa3_q;
                            out_pcsrc      <= pcsrc_q;
                            out_regwrite   <= regwrite_q;
                            out_memtoreg   <= memtoreg_q;
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_lane_sequencer.sv
// Directed bench for memory_lane_sequencer: ALU pass-through, store, load with
// wait states and address wrap, back-to-back issue, reset mid-access, spurious ack.
module tb_memory_lane_sequencer;
    import gpu_pkg::*;

    logic          clk;
    logic          reset;
    logic          in_valid;
    vec_t          alu_result;
    logic [AW-1:0] ld_base;
    logic [AW-1:0] st_base;
    vec_t          write_data;
    logic [3:0]    wa3;
    logic          pcsrc, regwrite, memtoreg, memwrite;
    logic          stall, dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [N-1:0]  dmem_wdata;
    logic          dmem_ack;
    logic [N-1:0]  dmem_rdata;
    logic          out_valid;
    vec_t          out_alu_result, out_read_data;
    logic [3:0]    out_wa3;
    logic          out_pcsrc, out_regwrite, out_memtoreg;

    int vectors = 0;
    int miscompares = 0;

    memory_lane_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .ld_base(ld_base), .st_base(st_base), .write_data(write_data), .wa3(wa3),
        .pcsrc(pcsrc), .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_alu_result(out_alu_result),
        .out_read_data(out_read_data), .out_wa3(out_wa3), .out_pcsrc(out_pcsrc),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] l0, input logic [N-1:0] l1, input logic [N-1:0] l2);
        vec_t v;
        v[0] = l0;
        v[1] = l1;
        v[2] = l2;
        return v;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; ld_base = '0; st_base = '0;
        write_data = '0; wa3 = '0; pcsrc = 1'b0; regwrite = 1'b0; memtoreg = 1'b0;
        memwrite = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        step(); step();

        check("rst_stall", 64'(stall), 64'd0);
        check("rst_req", 64'(dmem_req), 64'd0);
        check("rst_we", 64'(dmem_we), 64'd0);
        check("rst_addr", 64'(dmem_addr), 64'd0);
        check("rst_wdata", 64'(dmem_wdata), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wa3", 64'(out_wa3), 64'd0);
        check("rst_out_alu", 64'(out_alu_result), 64'd0);

        // Spurious ack in IDLE
        reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 18'h3AAAA;
        step();
        check("spur_stall", 64'(stall), 64'd0);
        check("spur_out_valid", 64'(out_valid), 64'd0);
        check("spur_req", 64'(dmem_req), 64'd0);
        dmem_ack = 1'b0;
        step();
        check("spur_out_valid2", 64'(out_valid), 64'd0);

        // ALU op: one-cycle pass-through
        in_valid = 1'b1; alu_result = mk(5, 6, 7); wa3 = 4'd3; regwrite = 1'b1;
        pcsrc = 1'b1;
        #1;
        check("alu_stall_pre", 64'(stall), 64'd0);
        step();
        in_valid = 1'b0; pcsrc = 1'b0;
        check("alu_out_valid", 64'(out_valid), 64'd1);
        check("alu_out_alu", 64'(out_alu_result), 64'(mk(5, 6, 7)));
        check("alu_out_wa3", 64'(out_wa3), 64'd3);
        check("alu_out_regwrite", 64'(out_regwrite), 64'd1);
        check("alu_out_pcsrc", 64'(out_pcsrc), 64'd1);
        check("alu_out_rd", 64'(out_read_data), 64'd0);
        check("alu_stall", 64'(stall), 64'd0);
        step();
        check("alu_pulse_end", 64'(out_valid), 64'd0);
        check("alu_hold_wa3", 64'(out_wa3), 64'd3);

        // Store, ack every cycle
        in_valid = 1'b1; memwrite = 1'b1; st_base = 10'h010; ld_base = 10'h200;
        write_data = mk(18'hA, 18'hB, 18'hC); wa3 = 4'd5; regwrite = 1'b0;
        alu_result = mk(1, 1, 1);
        step();
        in_valid = 1'b0; memwrite = 1'b0; dmem_ack = 1'b1;
        check("st0_stall", 64'(stall), 64'd1);
        check("st0_req", 64'(dmem_req), 64'd1);
        check("st0_we", 64'(dmem_we), 64'd1);
        check("st0_addr", 64'(dmem_addr), 64'h010);
        check("st0_wdata", 64'(dmem_wdata), 64'hA);
        step();
        check("st1_stall", 64'(stall), 64'd1);
        check("st1_addr", 64'(dmem_addr), 64'h011);
        check("st1_wdata", 64'(dmem_wdata), 64'hB);
        check("st1_out_valid", 64'(out_valid), 64'd0);
        step();
        check("st2_stall", 64'(stall), 64'd1);
        check("st2_addr", 64'(dmem_addr), 64'h012);
        check("st2_wdata", 64'(dmem_wdata), 64'hC);
        step();
        dmem_ack = 1'b0;
        check("st_out_valid", 64'(out_valid), 64'd1);
        check("st_stall_end", 64'(stall), 64'd0);
        check("st_req_end", 64'(dmem_req), 64'd0);
        check("st_out_rd", 64'(out_read_data), 64'd0);
        check("st_out_wa3", 64'(out_wa3), 64'd5);
        check("st_out_alu", 64'(out_alu_result), 64'(mk(1, 1, 1)));

        // Load with two wait cycles per lane, address wraps past 0x3FF
        in_valid = 1'b1; memtoreg = 1'b1; ld_base = 10'h3FE; st_base = 10'h0F0; wa3 = 4'd6;
        regwrite = 1'b1;
        step();
        in_valid = 1'b0;
        check("ld_we", 64'(dmem_we), 64'd0);
        check("ld0_addr", 64'(dmem_addr), 64'h3FE);
        step();
        check("ld0_wait1_addr", 64'(dmem_addr), 64'h3FE);
        check("ld0_wait1_req", 64'(dmem_req), 64'd1);
        step();
        check("ld0_wait2_addr", 64'(dmem_addr), 64'h3FE);
        dmem_ack = 1'b1; dmem_rdata = 18'd1;
        step();
        dmem_ack = 1'b0; dmem_rdata = 18'h3FFFF;
        check("ld1_addr", 64'(dmem_addr), 64'h3FF);
        step();
        check("ld1_wait1_addr", 64'(dmem_addr), 64'h3FF);
        step();
        check("ld1_wait2_addr", 64'(dmem_addr), 64'h3FF);
        check("ld1_wait_out_valid", 64'(out_valid), 64'd0);
        dmem_ack = 1'b1; dmem_rdata = 18'd2;
        step();
        dmem_ack = 1'b0; dmem_rdata = 18'h3FFFF;
        check("ld2_addr_wrap", 64'(dmem_addr), 64'h000);
        step();
        check("ld2_wait1_addr", 64'(dmem_addr), 64'h000);
        step();
        check("ld2_wait2_stall", 64'(stall), 64'd1);
        dmem_ack = 1'b1; dmem_rdata = 18'd3;
        step();
        dmem_ack = 1'b0;
        check("ld_out_valid", 64'(out_valid), 64'd1);
        check("ld_out_rd", 64'(out_read_data), 64'(mk(1, 2, 3)));
        check("ld_out_memtoreg", 64'(out_memtoreg), 64'd1);
        check("ld_out_wa3", 64'(out_wa3), 64'd6);
        check("ld_stall_end", 64'(stall), 64'd0);

        // Back-to-back: ALU op presented while the load is in ACCESS
        dmem_ack = 1'b1; in_valid = 1'b1; memtoreg = 1'b1; ld_base = 10'h020; wa3 = 4'd7;
        dmem_rdata = 18'h11;
        step();
        memtoreg = 1'b0; wa3 = 4'd9; alu_result = mk(1, 2, 3);
        check("b2b_lane0_addr", 64'(dmem_addr), 64'h020);
        step();
        dmem_rdata = 18'h22;
        check("b2b_stall_l1", 64'(stall), 64'd1);
        check("b2b_no_early_valid", 64'(out_valid), 64'd0);
        step();
        dmem_rdata = 18'h33;
        check("b2b_stall_l2", 64'(stall), 64'd1);
        step();
        check("b2b_ld_valid", 64'(out_valid), 64'd1);
        check("b2b_ld_wa3", 64'(out_wa3), 64'd7);
        check("b2b_ld_rd", 64'(out_read_data), 64'(mk(18'h11, 18'h22, 18'h33)));
        check("b2b_idle", 64'(stall), 64'd0);
        step();
        in_valid = 1'b0; dmem_ack = 1'b0;
        check("b2b_alu_valid", 64'(out_valid), 64'd1);
        check("b2b_alu_wa3", 64'(out_wa3), 64'd9);
        check("b2b_alu_rd", 64'(out_read_data), 64'd0);
        check("b2b_alu_res", 64'(out_alu_result), 64'(mk(1, 2, 3)));
        step();
        check("b2b_pulse_end", 64'(out_valid), 64'd0);

        // Reset asserted together with the lane-1 ack
        in_valid = 1'b1; memwrite = 1'b1; st_base = 10'h040; wa3 = 4'd4;
        step();
        in_valid = 1'b0; memwrite = 1'b0; dmem_ack = 1'b1;
        step();
        check("rma_lane1_addr", 64'(dmem_addr), 64'h041);
        reset = 1'b1;
        step();
        check("rma_req", 64'(dmem_req), 64'd0);
        check("rma_stall", 64'(stall), 64'd0);
        check("rma_out_valid", 64'(out_valid), 64'd0);
        check("rma_out_wa3", 64'(out_wa3), 64'd0);
        reset = 1'b0;
        step();
        dmem_ack = 1'b0;
        check("rma_stay_idle", 64'(stall), 64'd0);
        check("rma_no_valid", 64'(out_valid), 64'd0);
        step();
        check("rma_no_valid2", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
